// File: rtl/rr_slot_scheduler_if.sv
// Signal bundle between the requesting channels (master) and one output-port
// slot scheduler (slave).
interface rr_slot_scheduler_if #(
  parameter int P_CHANNEL_NUM = 8,
  parameter int P_IDX_W       = 3
);
  // Level-based handshake, no ready/valid pair: a channel holds i_req[n] high
  // for as long as it wants the path. The slave answers with o_grant
  // (one-hot owner) and a one-cycle o_cfg_valid when the owner changes.
  // o_grant_valid marks the open data slot. i_done is a level sampled only
  // while the slot is open and ends that slot at the same edge.
  logic [P_CHANNEL_NUM-1:0] i_req;
  logic                     i_done;
  logic [P_CHANNEL_NUM-1:0] o_grant;
  logic                     o_grant_valid;
  logic                     o_cfg_valid;
  logic [P_IDX_W-1:0]       o_cfg_port;
  logic                     o_busy;

  modport master (
    output i_req, i_done,
    input  o_grant, o_grant_valid, o_cfg_valid, o_cfg_port, o_busy
  );

  modport slave (
    input  i_req, i_done,
    output o_grant, o_grant_valid, o_cfg_valid, o_cfg_port, o_busy
  );
endinterface

// File: rtl/rr_slot_scheduler.sv
// Round-robin time-slot scheduler for one optical output port: grant,
// reconfigure strobe, guard settle interval, then a bounded data slot.
module rr_slot_scheduler #(
  parameter int P_CHANNEL_NUM = 8,
  parameter int P_SLOT_CYC    = 16,
  parameter int P_GUARD_CYC   = 4,
  parameter int P_IDX_W       = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rr_slot_scheduler_if.slave  sched,
  output logic [1:0]          o_dbg_state
);

  localparam int CNT_MAX = (P_SLOT_CYC > P_GUARD_CYC) ? P_SLOT_CYC : P_GUARD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(P_SLOT_CYC);
  localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'(P_GUARD_CYC);
  localparam logic [P_IDX_W-1:0] IDX_LAST   = P_IDX_W'(P_CHANNEL_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SLOT  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [P_CHANNEL_NUM-1:0] grant_q, grant_d;
  logic [P_CHANNEL_NUM-1:0] ptr_q, ptr_d;
  logic [P_IDX_W-1:0]       port_q, port_d;
  logic                     cfg_q, cfg_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [P_IDX_W-1:0]       ptr_idx;
  logic [P_IDX_W-1:0]       arb_base;
  logic                     win_found;
  logic [P_IDX_W-1:0]       win_idx;

  // Lowest requesting index at or above base, wrapping; scanned from the far
  // end so the closest hit overwrites the others.
  function automatic logic [P_IDX_W:0] pick(input logic [P_CHANNEL_NUM-1:0] req,
                                             input logic [P_IDX_W-1:0]       base);
    logic [P_IDX_W:0] sum;
    logic [P_IDX_W:0] res;
    res = '0;
    for (int i = P_CHANNEL_NUM - 1; i >= 0; i--) begin
      sum = {1'b0, base} + (P_IDX_W+1)'(i);
      if (sum >= (P_IDX_W+1)'(P_CHANNEL_NUM)) begin
        sum = sum - (P_IDX_W+1)'(P_CHANNEL_NUM);
      end
      if (req[sum[P_IDX_W-1:0]]) begin
        res = {1'b1, sum[P_IDX_W-1:0]};
      end
    end
    return res;
  endfunction

  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < P_CHANNEL_NUM; i++) begin
      if (ptr_q[i]) begin
        ptr_idx = P_IDX_W'(i);
      end
    end
  end

  // At the end of a slot the pointer moves past the owner in the same edge,
  // so arbitration already sees the rotated value.
  always_comb begin
    if (state_q == ST_SLOT) begin
      arb_base = (port_q == IDX_LAST) ? '0 : port_q + P_IDX_W'(1);
    end else begin
      arb_base = ptr_idx;
    end
    {win_found, win_idx} = pick(sched.i_req, arb_base);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    cfg_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GUARD;
          grant_d = P_CHANNEL_NUM'(1) << win_idx;
          port_d  = win_idx;
          cfg_d   = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_SLOT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SLOT: begin
        if (sched.i_done || (cnt_q == SLOT_LAST)) begin
          ptr_d = {grant_q[P_CHANNEL_NUM-2:0], grant_q[P_CHANNEL_NUM-1]};
          if (!win_found) begin
            state_d = ST_IDLE;
            grant_d = '0;
            port_d  = '0;
            cnt_d   = '0;
          end else if (win_idx != port_q) begin
            state_d = ST_GUARD;
            grant_d = P_CHANNEL_NUM'(1) << win_idx;
            port_d  = win_idx;
            cfg_d   = 1'b1;
            cnt_d   = CNT_W'(1);
          end else begin
            // Sole requester keeps the path: the switch is already set.
            cnt_d = CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        port_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= P_CHANNEL_NUM'(1);
      port_q  <= '0;
      cfg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sched.o_grant       = grant_q;
  assign sched.o_grant_valid = (state_q == ST_SLOT);
  assign sched.o_cfg_valid   = cfg_q;
  assign sched.o_cfg_port    = port_q;
  assign sched.o_busy        = (state_q != ST_IDLE);
  assign o_dbg_state         = state_q;

endmodule

// File: tb/tb_rr_slot_scheduler.sv
// Bench for rr_slot_scheduler: per-cycle comparison against a behavioural
// slot model, plus directed scenarios with hand-computed expectations.
module tb_rr_slot_scheduler;
  localparam int N = 8;
  localparam int S = 16;
  localparam int G = 4;
  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_slot_scheduler_if #(.P_CHANNEL_NUM(N), .P_IDX_W(W)) bus ();
  logic [1:0] dbg_state;

  rr_slot_scheduler #(
    .P_CHANNEL_NUM(N),
    .P_SLOT_CYC   (S),
    .P_GUARD_CYC  (G),
    .P_IDX_W      (W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .sched       (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner index (-1 = none), guard cycles still to run, current slot cycle.
  int m_owner;
  int m_ptr;
  int m_guard;
  int m_slot;
  bit m_cfg;

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int i = 0; i < N; i++) begin
      if (req[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_guard = 0;
    m_slot  = 0;
    m_cfg   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic done);
    bit cfg_n;
    int w;
    cfg_n = 1'b0;
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner = pick(req, m_ptr);
        m_guard = G;
        cfg_n   = 1'b1;
      end
    end else if (m_guard > 0) begin
      m_guard--;
      if (m_guard == 0) m_slot = 1;
    end else if (done || m_slot == S) begin
      m_ptr = (m_owner + 1) % N;
      w = pick(req, m_ptr);
      if (w < 0) begin
        m_owner = -1;
        m_slot  = 0;
      end else if (w != m_owner) begin
        m_owner = w;
        m_slot  = 0;
        m_guard = G;
        cfg_n   = 1'b1;
      end else begin
        m_slot = 1;
      end
    end else begin
      m_slot++;
    end
    m_cfg = cfg_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(bus.i_req, bus.i_done);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [N-1:0] e_grant;
    logic         prev_cfg;
    prev_cfg = 1'b0;
    forever begin
      @(negedge clk);
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      check("cmp_grant", bus.o_grant, e_grant);
      check("cmp_grant_valid", bus.o_grant_valid, (m_owner >= 0 && m_guard == 0) ? 1 : 0);
      check("cmp_cfg_valid", bus.o_cfg_valid, m_cfg);
      check("cmp_cfg_port", bus.o_cfg_port, (m_owner >= 0) ? m_owner : 0);
      check("cmp_busy", bus.o_busy, (m_owner >= 0) ? 1 : 0);
      check("inv_onehot0", $onehot0(bus.o_grant), 1);
      check("inv_cfg_twice", prev_cfg && bus.o_cfg_valid, 0);
      check("inv_cfg_in_slot", bus.o_cfg_valid && bus.o_grant_valid, 0);
      prev_cfg = bus.o_cfg_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req  = '0;
    bus.i_done = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int ncfg;
    int ngv;
    int last;
    bus.i_req  = '0;
    bus.i_done = 1'b0;

    // Reset state
    do_reset();
    check("rst_grant", bus.o_grant, 0);
    check("rst_gv", bus.o_grant_valid, 0);
    check("rst_cfg", bus.o_cfg_valid, 0);
    check("rst_port", bus.o_cfg_port, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_state", dbg_state, 0);

    // Single request on channel 3, latency and slot window
    bus.i_req = 8'h08;
    tick(1);
    check("t1_cfg", bus.o_cfg_valid, 1);
    check("t1_port", bus.o_cfg_port, 3);
    check("t1_grant", bus.o_grant, 8'h08);
    bus.i_req = 8'h00;
    for (int j = 2; j <= 22; j++) begin
      tick(1);
      check("t1_gv_window", bus.o_grant_valid, (j >= 5 && j <= 20) ? 1 : 0);
      check("t1_cfg_once", bus.o_cfg_valid, 0);
    end
    check("t1_idle_grant", bus.o_grant, 0);
    check("t1_idle_busy", bus.o_busy, 0);

    // All channels requesting: fairness order and spacing
    do_reset();
    for (int i = 0; i < N; i++) exp_q.push_back(W'(i));
    exp_q.push_back(W'(0));
    bus.i_req = 8'hFF;
    ncfg = 0;
    last = -1;
    for (int j = 1; j <= 165; j++) begin
      tick(1);
      if (bus.o_cfg_valid) begin
        ncfg++;
        if (exp_q.size() > 0) check("t2_order", bus.o_cfg_port, exp_q.pop_front());
        if (last >= 0) check("t2_spacing", j - last, G + S);
        last = j;
      end
    end
    check("t2_cfg_count", ncfg, 9);
    check("t2_queue_empty", exp_q.size(), 0);

    // Sole requester keeps the path with no guard gaps
    do_reset();
    bus.i_req = 8'h20;
    ncfg = 0;
    ngv  = 0;
    for (int j = 1; j <= 60; j++) begin
      tick(1);
      ncfg += int'(bus.o_cfg_valid);
      ngv  += int'(bus.o_grant_valid);
      if (j >= 5) check("t3_gv_continuous", bus.o_grant_valid, 1);
    end
    check("t3_cfg_count", ncfg, 1);
    check("t3_gv_count", ngv, 56);
    check("t3_port", bus.o_cfg_port, 5);

    // Early done from owner 2 hands over to channel 6
    do_reset();
    bus.i_req = 8'h04;
    tick(1);
    check("t4_port_first", bus.o_cfg_port, 2);
    tick(1);
    bus.i_req = 8'h41;
    tick(5);
    check("t4_in_slot", bus.o_grant_valid, 1);
    bus.i_done = 1'b1;
    tick(1);
    bus.i_done = 1'b0;
    check("t4_cfg", bus.o_cfg_valid, 1);
    check("t4_port", bus.o_cfg_port, 6);
    check("t4_grant", bus.o_grant, 8'h40);
    check("t4_gv", bus.o_grant_valid, 0);

    // Done during guard and owner request drop mid-slot are both ignored
    do_reset();
    bus.i_req = 8'h02;
    ngv = 0;
    for (int j = 1; j <= 25; j++) begin
      tick(1);
      if (j == 1) check("t5_port", bus.o_cfg_port, 1);
      if (j == 2) bus.i_done = 1'b1;
      if (j == 3) bus.i_done = 1'b0;
      if (j == 8) bus.i_req = 8'h00;
      if (j == 20) check("t5_gv_last", bus.o_grant_valid, 1);
      if (j == 21) check("t5_gv_after", bus.o_grant_valid, 0);
      ngv += int'(bus.o_grant_valid);
    end
    check("t5_gv_count", ngv, 16);
    check("t5_idle_grant", bus.o_grant, 0);

    // Asynchronous reset mid-guard, pointer returns to channel 0
    do_reset();
    bus.i_req = 8'h18;
    tick(1);
    check("t6_port_first", bus.o_cfg_port, 3);
    tick(4);
    bus.i_done = 1'b1;
    tick(1);
    bus.i_done = 1'b0;
    check("t6_port_second", bus.o_cfg_port, 4);
    check("t6_cfg_second", bus.o_cfg_valid, 1);
    tick(1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_grant", bus.o_grant, 0);
    check("t6_rst_gv", bus.o_grant_valid, 0);
    check("t6_rst_cfg", bus.o_cfg_valid, 0);
    check("t6_rst_port", bus.o_cfg_port, 0);
    check("t6_rst_busy", bus.o_busy, 0);
    tick(2);
    rst = 1'b0;
    bus.i_req = 8'h81;
    tick(1);
    check("t6_post_port", bus.o_cfg_port, 0);
    check("t6_post_grant", bus.o_grant, 8'h01);
    check("t6_post_cfg", bus.o_cfg_valid, 1);
    bus.i_req = 8'h00;
    tick(2);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
